// File: rtl/psum_feedback_acc_pkg.sv
// rtl/psum_feedback_acc_pkg.sv - shared widths and saturation constants for the psum feedback accumulator
package psum_feedback_acc_pkg;

  localparam int PSUM_W = 13;
  localparam int SUM_W  = 14;

  localparam logic [PSUM_W-1:0] SAT_POS = 13'h0FFF;
  localparam logic [PSUM_W-1:0] SAT_NEG = 13'h1000;

  localparam logic [1:0] OVF_POS = 2'b01;
  localparam logic [1:0] OVF_NEG = 2'b10;

endpackage

// File: rtl/psum_feedback_acc_if.sv
// rtl/psum_feedback_acc_if.sv - sum input stream and finished-result output stream
interface psum_feedback_acc_if;
  import psum_feedback_acc_pkg::*;

  logic [SUM_W-1:0]  sum_in;
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [PSUM_W-1:0] out_data;

  modport master (
    output sum_in, in_valid, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  sum_in, in_valid, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/psum_feedback_acc_sat.sv
// rtl/psum_feedback_acc_sat.sv - combinational 14->13 bit saturation of the adder_final sum
module psum_sat
  import psum_feedback_acc_pkg::*;
(
  input  logic [SUM_W-1:0]  sum_i,
  output logic [PSUM_W-1:0] sat_o
);

  always_comb begin
    sat_o = sum_i[PSUM_W-1:0];
    if (sum_i[SUM_W-1:SUM_W-2] == OVF_POS) begin
      sat_o = SAT_POS;
    end else if (sum_i[SUM_W-1:SUM_W-2] == OVF_NEG) begin
      sat_o = SAT_NEG;
    end
  end

endmodule

// File: rtl/psum_feedback_acc.sv
// rtl/psum_feedback_acc.sv - saturating feedback register that groups PASSES beats into one result
module psum_feedback_acc
  import psum_feedback_acc_pkg::*;
#(
  parameter int PASSES = 4,
  parameter bit RELU   = 1'b0,
  parameter int CW     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  psum_feedback_acc_if.slave bus,
  output logic [PSUM_W-1:0] pre_output,
  output logic [CW-1:0]     beat_cnt
);

  localparam logic [CW-1:0] LAST_IDX = CW'(PASSES - 1);

  logic [PSUM_W-1:0] pre_q, pre_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ov_q, ov_d;
  logic [PSUM_W-1:0] od_q, od_d;

  logic [PSUM_W-1:0] sat_val;
  logic [PSUM_W-1:0] res_val;
  logic              beat;
  logic              last_beat;

  psum_sat u_sat (
    .sum_i (bus.sum_in),
    .sat_o (sat_val)
  );

  assign bus.in_ready  = ~ov_q | bus.out_ready;
  assign beat          = bus.in_valid & bus.in_ready & ~flush;
  assign last_beat     = beat & (cnt_q == LAST_IDX);
  assign res_val       = (RELU && sat_val[PSUM_W-1]) ? '0 : sat_val;

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    ov_d  = ov_q;
    od_d  = od_q;

    if (flush) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (last_beat) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (beat) begin
      pre_d = sat_val;
      cnt_d = cnt_q + CW'(1);
    end

    // A new last beat in the handshake cycle refills the output with no bubble.
    if (ov_q && bus.out_ready) begin
      ov_d = 1'b0;
    end
    if (last_beat) begin
      ov_d = 1'b1;
      od_d = res_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      cnt_q <= '0;
      ov_q  <= 1'b0;
      od_q  <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      ov_q  <= ov_d;
      od_q  <= od_d;
    end
  end

  assign pre_output    = pre_q;
  assign beat_cnt      = cnt_q;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;

endmodule

// File: tb/tb_psum_feedback_acc.sv
// tb/tb_psum_feedback_acc.sv - bench for psum_feedback_acc across four PASSES/RELU configurations
module tb_psum_feedback_acc;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [13:0] sum_in;
  logic        in_valid;
  logic        out_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  psum_feedback_acc_if ifa ();
  psum_feedback_acc_if ifb ();
  psum_feedback_acc_if ifc ();
  psum_feedback_acc_if ifd ();

  assign ifa.sum_in = sum_in; assign ifa.in_valid = in_valid; assign ifa.out_ready = out_ready;
  assign ifb.sum_in = sum_in; assign ifb.in_valid = in_valid; assign ifb.out_ready = out_ready;
  assign ifc.sum_in = sum_in; assign ifc.in_valid = in_valid; assign ifc.out_ready = out_ready;
  assign ifd.sum_in = sum_in; assign ifd.in_valid = in_valid; assign ifd.out_ready = out_ready;

  logic [12:0] pre_a, pre_b, pre_c, pre_d;
  logic [3:0]  cnt_a, cnt_b, cnt_c, cnt_d;

  psum_feedback_acc #(.PASSES(4), .RELU(1'b0), .CW(4)) u_a (
    .clk(clk), .reset(reset), .flush(flush), .bus(ifa), .pre_output(pre_a), .beat_cnt(cnt_a));
  psum_feedback_acc #(.PASSES(2), .RELU(1'b0), .CW(4)) u_b (
    .clk(clk), .reset(reset), .flush(flush), .bus(ifb), .pre_output(pre_b), .beat_cnt(cnt_b));
  psum_feedback_acc #(.PASSES(4), .RELU(1'b1), .CW(4)) u_c (
    .clk(clk), .reset(reset), .flush(flush), .bus(ifc), .pre_output(pre_c), .beat_cnt(cnt_c));
  psum_feedback_acc #(.PASSES(1), .RELU(1'b1), .CW(4)) u_d (
    .clk(clk), .reset(reset), .flush(flush), .bus(ifd), .pre_output(pre_d), .beat_cnt(cnt_d));

  logic [12:0] d_pre [4];
  logic [3:0]  d_cnt [4];
  logic        d_ov  [4];
  logic [12:0] d_od  [4];
  logic        d_ir  [4];

  assign d_pre[0] = pre_a; assign d_cnt[0] = cnt_a; assign d_ov[0] = ifa.out_valid;
  assign d_pre[1] = pre_b; assign d_cnt[1] = cnt_b; assign d_ov[1] = ifb.out_valid;
  assign d_pre[2] = pre_c; assign d_cnt[2] = cnt_c; assign d_ov[2] = ifc.out_valid;
  assign d_pre[3] = pre_d; assign d_cnt[3] = cnt_d; assign d_ov[3] = ifd.out_valid;
  assign d_od[0] = ifa.out_data; assign d_ir[0] = ifa.in_ready;
  assign d_od[1] = ifb.out_data; assign d_ir[1] = ifb.in_ready;
  assign d_od[2] = ifc.out_data; assign d_ir[2] = ifc.in_ready;
  assign d_od[3] = ifd.out_data; assign d_ir[3] = ifd.in_ready;

  // Reference model: signed integer clamp and a plain beat counter per configuration.
  int m_pre [4];
  int m_cnt [4];
  int m_ov  [4];
  int m_od  [4];
  int cfg_p [4] = '{4, 2, 4, 1};
  int cfg_r [4] = '{0, 0, 1, 1};

  function automatic int clamp13(logic [13:0] x);
    int s;
    s = int'($signed(x));
    if (s > 4095) return 4095;
    if (s < -4096) return -4096;
    return s;
  endfunction

  task automatic model_step();
    int v;
    bit rdy, bt, lst;
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        m_pre[i] = 0; m_cnt[i] = 0; m_ov[i] = 0; m_od[i] = 0;
      end else begin
        v   = clamp13(sum_in);
        rdy = (m_ov[i] == 0) || out_ready;
        bt  = in_valid && rdy && !flush;
        lst = bt && (m_cnt[i] == cfg_p[i] - 1);
        if (m_ov[i] != 0 && out_ready) m_ov[i] = 0;
        if (lst) begin
          m_ov[i] = 1;
          m_od[i] = (cfg_r[i] != 0 && v < 0) ? 0 : v;
        end
        if (flush || lst) begin
          m_pre[i] = 0; m_cnt[i] = 0;
        end else if (bt) begin
          m_pre[i] = v; m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_tick();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rnd%0d.pre", i), 32'(d_pre[i]), 32'(m_pre[i] & 32'h1FFF));
      chk($sformatf("rnd%0d.cnt", i), 32'(d_cnt[i]), 32'(m_cnt[i]));
      chk($sformatf("rnd%0d.ov", i),  32'(d_ov[i]),  32'(m_ov[i]));
      chk($sformatf("rnd%0d.od", i),  32'(d_od[i]),  32'(m_od[i] & 32'h1FFF));
      chk($sformatf("rnd%0d.ir", i),  32'(d_ir[i]),  32'((m_ov[i] == 0) || out_ready));
    end
  endtask

  task automatic drive(logic v, logic [13:0] s, logic orr, logic fl);
    in_valid = v; sum_in = s; out_ready = orr; flush = fl;
  endtask

  typedef struct {
    logic        v;
    logic [13:0] s;
    logic        orr;
    logic        fl;
    logic [12:0] pre;
    logic [3:0]  cnt;
    logic        ov;
    logic [12:0] od;
    logic        ir;
  } vec_t;

  vec_t tbl [20];

  initial begin
    tbl[0]  = '{1'b1, 14'h0010, 1'b1, 1'b0, 13'h0010, 4'd1, 1'b0, 13'h0000, 1'b1};
    tbl[1]  = '{1'b1, 14'h0020, 1'b1, 1'b0, 13'h0020, 4'd2, 1'b0, 13'h0000, 1'b1};
    tbl[2]  = '{1'b1, 14'h0030, 1'b1, 1'b0, 13'h0030, 4'd3, 1'b0, 13'h0000, 1'b1};
    tbl[3]  = '{1'b1, 14'h0040, 1'b1, 1'b0, 13'h0000, 4'd0, 1'b1, 13'h0040, 1'b1};
    tbl[4]  = '{1'b0, 14'h0000, 1'b1, 1'b0, 13'h0000, 4'd0, 1'b0, 13'h0040, 1'b1};
    tbl[5]  = '{1'b1, 14'h1005, 1'b1, 1'b0, 13'h0FFF, 4'd1, 1'b0, 13'h0040, 1'b1};
    tbl[6]  = '{1'b1, 14'h0001, 1'b1, 1'b0, 13'h0001, 4'd2, 1'b0, 13'h0040, 1'b1};
    tbl[7]  = '{1'b1, 14'h0002, 1'b1, 1'b0, 13'h0002, 4'd3, 1'b0, 13'h0040, 1'b1};
    tbl[8]  = '{1'b1, 14'h2003, 1'b1, 1'b0, 13'h0000, 4'd0, 1'b1, 13'h1000, 1'b1};
    tbl[9]  = '{1'b0, 14'h0000, 1'b1, 1'b0, 13'h0000, 4'd0, 1'b0, 13'h1000, 1'b1};
    tbl[10] = '{1'b1, 14'h3FF0, 1'b1, 1'b0, 13'h1FF0, 4'd1, 1'b0, 13'h1000, 1'b1};
    tbl[11] = '{1'b1, 14'h0123, 1'b1, 1'b1, 13'h0000, 4'd0, 1'b0, 13'h1000, 1'b1};
    tbl[12] = '{1'b1, 14'h0005, 1'b1, 1'b0, 13'h0005, 4'd1, 1'b0, 13'h1000, 1'b1};
    tbl[13] = '{1'b1, 14'h0006, 1'b1, 1'b0, 13'h0006, 4'd2, 1'b0, 13'h1000, 1'b1};
    tbl[14] = '{1'b0, 14'h0000, 1'b1, 1'b1, 13'h0000, 4'd0, 1'b0, 13'h1000, 1'b1};
    tbl[15] = '{1'b1, 14'h0001, 1'b1, 1'b0, 13'h0001, 4'd1, 1'b0, 13'h1000, 1'b1};
    tbl[16] = '{1'b1, 14'h0002, 1'b1, 1'b0, 13'h0002, 4'd2, 1'b0, 13'h1000, 1'b1};
    tbl[17] = '{1'b1, 14'h0003, 1'b1, 1'b0, 13'h0003, 4'd3, 1'b0, 13'h1000, 1'b1};
    tbl[18] = '{1'b1, 14'h0004, 1'b1, 1'b0, 13'h0000, 4'd0, 1'b1, 13'h0004, 1'b1};
    tbl[19] = '{1'b0, 14'h0000, 1'b1, 1'b0, 13'h0000, 4'd0, 1'b0, 13'h0004, 1'b1};

    reset = 1'b1;
    drive(1'b0, 14'h0, 1'b1, 1'b0);
    tick(); tick();
    reset = 1'b0;
    chk("rst.pre", 32'(pre_a), 32'h0);
    chk("rst.cnt", 32'(cnt_a), 32'h0);
    chk("rst.ov",  32'(ifa.out_valid), 32'h0);
    chk("rst.od",  32'(ifa.out_data), 32'h0);
    chk("rst.ir",  32'(ifa.in_ready), 32'h1);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].orr, tbl[i].fl);
      tick();
      chk($sformatf("vec%0d.pre", i), 32'(pre_a), 32'(tbl[i].pre));
      chk($sformatf("vec%0d.cnt", i), 32'(cnt_a), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d.ov", i),  32'(ifa.out_valid), 32'(tbl[i].ov));
      chk($sformatf("vec%0d.od", i),  32'(ifa.out_data), 32'(tbl[i].od));
      chk($sformatf("vec%0d.ir", i),  32'(ifa.in_ready), 32'(tbl[i].ir));
    end

    // RELU clamps the negative result only on out_data.
    drive(1'b1, 14'h0001, 1'b1, 1'b0); tick();
    drive(1'b1, 14'h0002, 1'b1, 1'b0); tick();
    drive(1'b1, 14'h0003, 1'b1, 1'b0); tick();
    drive(1'b1, 14'h3FF0, 1'b1, 1'b0); tick();
    chk("relu.od",    32'(ifc.out_data), 32'h0);
    chk("relu.ov",    32'(ifc.out_valid), 32'h1);
    chk("relu.pre",   32'(pre_c), 32'h0);
    chk("norelu.od",  32'(ifa.out_data), 32'h1FF0);
    drive(1'b0, 14'h0, 1'b1, 1'b0); tick();

    drive(1'b1, 14'h0011, 1'b0, 1'b0); tick();
    drive(1'b1, 14'h0022, 1'b0, 1'b0); tick();
    drive(1'b1, 14'h0033, 1'b0, 1'b0); tick();
    drive(1'b1, 14'h0044, 1'b0, 1'b0); tick();
    chk("bp.ov0", 32'(ifa.out_valid), 32'h1);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 14'h0777, 1'b0, 1'b0);
      tick();
      chk($sformatf("bp%0d.ir", k),  32'(ifa.in_ready), 32'h0);
      chk($sformatf("bp%0d.od", k),  32'(ifa.out_data), 32'h0044);
      chk($sformatf("bp%0d.ov", k),  32'(ifa.out_valid), 32'h1);
      chk($sformatf("bp%0d.pre", k), 32'(pre_a), 32'h0);
      chk($sformatf("bp%0d.cnt", k), 32'(cnt_a), 32'h0);
    end
    drive(1'b0, 14'h0, 1'b1, 1'b0);
    #1;
    chk("bp.ir_comb", 32'(ifa.in_ready), 32'h1);
    tick();
    chk("bp.ov_done", 32'(ifa.out_valid), 32'h0);

    reset = 1'b1; tick(); reset = 1'b0;
    drive(1'b1, 14'd5, 1'b1, 1'b0); tick();
    chk("b2b.p1_od5", 32'(ifd.out_data), 32'd5);
    chk("b2b.p1_ov5", 32'(ifd.out_valid), 32'h1);
    chk("b2b.p2_pre5", 32'(pre_b), 32'd5);
    drive(1'b1, 14'd9, 1'b1, 1'b0); tick();
    chk("b2b.p2_od9", 32'(ifb.out_data), 32'd9);
    chk("b2b.p2_ov9", 32'(ifb.out_valid), 32'h1);
    chk("b2b.p1_od9", 32'(ifd.out_data), 32'd9);
    chk("b2b.p1_ov9", 32'(ifd.out_valid), 32'h1);
    drive(1'b1, 14'd7, 1'b1, 1'b0); tick();
    chk("b2b.p2_ov7", 32'(ifb.out_valid), 32'h0);
    chk("b2b.p1_od7", 32'(ifd.out_data), 32'd7);
    chk("b2b.p1_ov7", 32'(ifd.out_valid), 32'h1);
    drive(1'b1, 14'd3, 1'b1, 1'b0); tick();
    chk("b2b.p2_od3", 32'(ifb.out_data), 32'd3);
    chk("b2b.p2_ov3", 32'(ifb.out_valid), 32'h1);
    chk("b2b.p1_od3", 32'(ifd.out_data), 32'd3);
    chk("b2b.p1_pre", 32'(pre_d), 32'h0);

    drive(1'b0, 14'h0, 1'b1, 1'b0);
    reset = 1'b1;
    model_tick();
    reset = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      reset     = ($urandom_range(0, 299) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      sum_in    = 14'($urandom);
      model_tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
